// File: rtl/inst_decode_pkg.sv
// ============================================================================
// Module      : inst_decode_pkg
// Description : Shared types and constants for the decode-stage forwarder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_decode_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] waddr;
    } pend_entry_t;

    typedef struct packed {
        logic        we;
        logic        ready;
        logic [4:0]  waddr;
        logic [31:0] wrdata;
    } fwd_stage_t;

endpackage

`default_nettype wire

// File: rtl/regs_scoreboard.sv
// ============================================================================
// Module      : regs_scoreboard
// Description : Tagged scoreboard for long-latency register writers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regs_scoreboard #(
    parameter int READ_PORT = 2,
    parameter int N_PEND    = 4,
    parameter int TAG_W     = $clog2(N_PEND)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [READ_PORT-1:0][4:0] rd_addr_i,
    input  logic                      id_we_i,
    input  logic [4:0]                id_waddr_i,
    input  logic                      lat_issue_i,
    input  logic [4:0]                lat_waddr_i,
    input  logic                      lat_done_i,
    input  logic [TAG_W-1:0]          lat_done_tag_i,
    output logic                      lat_issue_ready_o,
    output logic [TAG_W-1:0]          lat_tag_o,
    output logic [READ_PORT-1:0]      rd_pend_o,
    output logic [READ_PORT-1:0]      rd_done_o,
    output logic                      waw_o
);
    import inst_decode_pkg::*;

    pend_entry_t             pend_q [N_PEND];
    pend_entry_t             pend_d [N_PEND];
    logic [N_PEND-1:0]       live;
    logic                    done_ok;
    logic                    any_free;
    logic                    issue_clash;

    always_comb begin
        done_ok     = lat_done_i && pend_q[lat_done_tag_i].valid;
        any_free    = 1'b0;
        lat_tag_o   = '0;
        issue_clash = 1'b0;
        waw_o       = 1'b0;
        rd_pend_o   = '0;
        rd_done_o   = '0;
        // A completing entry is neither a hazard nor a free slot this cycle.
        for (int i = 0; i < N_PEND; i++) begin
            live[i] = pend_q[i].valid && !(done_ok && lat_done_tag_i == TAG_W'(i));
        end
        for (int i = N_PEND - 1; i >= 0; i--) begin
            if (!pend_q[i].valid) begin
                any_free  = 1'b1;
                lat_tag_o = TAG_W'(i);
            end
        end
        for (int i = 0; i < N_PEND; i++) begin
            if (live[i] && pend_q[i].waddr == lat_waddr_i) issue_clash = 1'b1;
            if (live[i] && pend_q[i].waddr == id_waddr_i && id_we_i) waw_o = 1'b1;
            for (int p = 0; p < READ_PORT; p++) begin
                if (live[i] && pend_q[i].waddr == rd_addr_i[p]) rd_pend_o[p] = 1'b1;
            end
        end
        for (int p = 0; p < READ_PORT; p++) begin
            rd_done_o[p] = done_ok && pend_q[lat_done_tag_i].waddr == rd_addr_i[p];
        end
        lat_issue_ready_o = any_free && !issue_clash;
    end

    always_comb begin
        for (int i = 0; i < N_PEND; i++) begin
            pend_d[i] = pend_q[i];
        end
        if (done_ok) begin
            pend_d[lat_done_tag_i].valid = 1'b0;
        end
        if (lat_issue_i && lat_issue_ready_o) begin
            pend_d[lat_tag_o].valid = 1'b1;
            pend_d[lat_tag_o].waddr = lat_waddr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PEND; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PEND; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regs_forward_sb.sv
// ============================================================================
// Module      : regs_forward_sb
// Description : Multi-stage operand forwarder with long-latency scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regs_forward_sb #(
    parameter int READ_PORT = 2,
    parameter int N_STAGE   = 2,
    parameter int N_PEND    = 4,
    parameter int TAG_W     = $clog2(N_PEND)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [READ_PORT-1:0][4:0]  regs_raddr_i,
    input  logic [READ_PORT-1:0][31:0] regs_rddata_i,
    input  logic                       id_we_i,
    input  logic [4:0]                 id_waddr_i,
    input  logic [N_STAGE-1:0]         stg_we_i,
    input  logic [N_STAGE-1:0][4:0]    stg_waddr_i,
    input  logic [N_STAGE-1:0][31:0]   stg_wrdata_i,
    input  logic [N_STAGE-1:0]         stg_ready_i,
    input  logic                       lat_issue_i,
    input  logic [4:0]                 lat_waddr_i,
    output logic                       lat_issue_ready_o,
    output logic [TAG_W-1:0]           lat_tag_o,
    input  logic                       lat_done_i,
    input  logic [TAG_W-1:0]           lat_done_tag_i,
    input  logic [31:0]                lat_done_wrdata_i,
    output logic [READ_PORT-1:0][31:0] regs_rddata_o,
    output logic                       stall_o,
    output logic [31:0]                stall_cnt_o
);
    import inst_decode_pkg::*;

    fwd_stage_t             stg [N_STAGE];
    logic [READ_PORT-1:0]   sb_pend;
    logic [READ_PORT-1:0]   sb_done;
    logic                   sb_waw;
    logic [READ_PORT-1:0]   hit;
    logic [READ_PORT-1:0]   port_stall;
    logic [31:0]            stall_cnt_q;
    logic [31:0]            stall_cnt_d;

    for (genvar s = 0; s < N_STAGE; s++) begin : g_stage
        assign stg[s] = {stg_we_i[s], stg_ready_i[s], stg_waddr_i[s], stg_wrdata_i[s]};
    end

    regs_scoreboard #(
        .READ_PORT (READ_PORT),
        .N_PEND    (N_PEND),
        .TAG_W     (TAG_W)
    ) u_sb (
        .clk               (clk),
        .rst               (rst),
        .rd_addr_i         (regs_raddr_i),
        .id_we_i           (id_we_i),
        .id_waddr_i        (id_waddr_i),
        .lat_issue_i       (lat_issue_i),
        .lat_waddr_i       (lat_waddr_i),
        .lat_done_i        (lat_done_i),
        .lat_done_tag_i    (lat_done_tag_i),
        .lat_issue_ready_o (lat_issue_ready_o),
        .lat_tag_o         (lat_tag_o),
        .rd_pend_o         (sb_pend),
        .rd_done_o         (sb_done),
        .waw_o             (sb_waw)
    );

    // Youngest stage first; the first address match decides, ready or not.
    always_comb begin
        hit        = '0;
        port_stall = '0;
        for (int p = 0; p < READ_PORT; p++) begin
            regs_rddata_o[p] = regs_rddata_i[p];
            if (regs_raddr_i[p] == REG_ZERO) begin
                regs_rddata_o[p] = 32'h0;
            end else begin
                for (int s = 0; s < N_STAGE; s++) begin
                    if (!hit[p] && stg[s].we && stg[s].waddr == regs_raddr_i[p]) begin
                        hit[p] = 1'b1;
                        if (stg[s].ready) regs_rddata_o[p] = stg[s].wrdata;
                        else              port_stall[p]    = 1'b1;
                    end
                end
                if (!hit[p] && sb_done[p]) begin
                    hit[p]           = 1'b1;
                    regs_rddata_o[p] = lat_done_wrdata_i;
                end
                if (!hit[p] && sb_pend[p]) begin
                    port_stall[p] = 1'b1;
                end
            end
        end
        stall_o = (|port_stall) || (sb_waw && id_waddr_i != REG_ZERO);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_regs_forward_sb.sv
// ============================================================================
// Module      : tb_regs_forward_sb
// Description : Directed vector bench for regs_forward_sb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regs_forward_sb;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][4:0]  raddr;
    logic [1:0][31:0] rfdata;
    logic             id_we;
    logic [4:0]       id_waddr;
    logic [1:0]       stg_we;
    logic [1:0][4:0]  stg_waddr;
    logic [1:0][31:0] stg_wrdata;
    logic [1:0]       stg_ready;
    logic             lat_issue;
    logic [4:0]       lat_waddr;
    logic             lat_ready;
    logic [1:0]       lat_tag;
    logic             lat_done;
    logic [1:0]       lat_done_tag;
    logic [31:0]      lat_done_wrdata;
    logic [1:0][31:0] rdata;
    logic             stall;
    logic [31:0]      stall_cnt;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_cnt = 0;

    always #5 clk = ~clk;

    regs_forward_sb #(.READ_PORT(2), .N_STAGE(2), .N_PEND(4), .TAG_W(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .regs_raddr_i      (raddr),
        .regs_rddata_i     (rfdata),
        .id_we_i           (id_we),
        .id_waddr_i        (id_waddr),
        .stg_we_i          (stg_we),
        .stg_waddr_i       (stg_waddr),
        .stg_wrdata_i      (stg_wrdata),
        .stg_ready_i       (stg_ready),
        .lat_issue_i       (lat_issue),
        .lat_waddr_i       (lat_waddr),
        .lat_issue_ready_o (lat_ready),
        .lat_tag_o         (lat_tag),
        .lat_done_i        (lat_done),
        .lat_done_tag_i    (lat_done_tag),
        .lat_done_wrdata_i (lat_done_wrdata),
        .regs_rddata_o     (rdata),
        .stall_o           (stall),
        .stall_cnt_o       (stall_cnt)
    );

    typedef struct {
        logic [4:0]  ra0, ra1;
        logic [31:0] rf0, rf1;
        logic [1:0]  we, rdy;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  dchk;
        logic [31:0] e0, e1;
        logic        es;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        raddr = '0; rfdata = '0; id_we = 1'b0; id_waddr = '0;
        stg_we = '0; stg_waddr = '0; stg_wrdata = '0; stg_ready = '0;
        lat_issue = 1'b0; lat_waddr = '0;
        lat_done = 1'b0; lat_done_tag = '0; lat_done_wrdata = '0;
    endtask

    // Issuing while the scoreboard refuses is a protocol error on the bench side.
    always @(posedge clk) begin
        if (!rst && lat_issue && !lat_ready) begin
            n_bad++;
            $display("FAIL protocol: issue with ready=%0d", lat_ready);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit=%0d", $time, 100000);
        $fatal(1, "watchdog");
    end

    initial begin
        //           ra0 ra1 rf0        rf1        we     rdy    wa0 wa1 wd0           wd1       dchk   e0           e1         es
        vec[0] = '{5'd5, 5'd6,  32'hA0A0, 32'hB0B0, 2'b11, 2'b11, 5'd5, 5'd5, 32'h11, 32'h22, 2'b11, 32'h11, 32'hB0B0, 1'b0};
        vec[1] = '{5'd5, 5'd6,  32'hA0A0, 32'hB0B0, 2'b10, 2'b11, 5'd5, 5'd5, 32'h11, 32'h22, 2'b11, 32'h22, 32'hB0B0, 1'b0};
        vec[2] = '{5'd7, 5'd8,  32'hC0C0, 32'hD0D0, 2'b11, 2'b10, 5'd7, 5'd7, 32'h00, 32'h33, 2'b10, 32'h0,  32'hD0D0, 1'b1};
        vec[3] = '{5'd7, 5'd8,  32'hC0C0, 32'hD0D0, 2'b11, 2'b10, 5'd7, 5'd7, 32'h00, 32'h33, 2'b10, 32'h0,  32'hD0D0, 1'b1};
        vec[4] = '{5'd7, 5'd8,  32'hC0C0, 32'hD0D0, 2'b11, 2'b11, 5'd7, 5'd7, 32'hAB, 32'h33, 2'b11, 32'hAB, 32'hD0D0, 1'b0};
        vec[5] = '{5'd0, 5'd3,  32'h1234, 32'h4444, 2'b11, 2'b11, 5'd0, 5'd3, 32'hFFFF_FFFF, 32'h77, 2'b11, 32'h0, 32'h77, 1'b0};
        vec[6] = '{5'd4, 5'd3,  32'h4040, 32'h4444, 2'b10, 2'b01, 5'd0, 5'd3, 32'h00, 32'h77, 2'b01, 32'h4040, 32'h0, 1'b1};
        vec[7] = '{5'd9, 5'd10, 32'h0DEA, 32'h0BEE, 2'b00, 2'b11, 5'd9, 5'd10, 32'h1, 32'h2, 2'b11, 32'h0DEA, 32'h0BEE, 1'b0};
        vec[8] = '{5'd12, 5'd12, 32'h1, 32'h2, 2'b11, 2'b10, 5'd13, 5'd12, 32'h9, 32'h55, 2'b11, 32'h55, 32'h55, 1'b0};

        idle();
        rst = 1'b1;
        #12 rst = 1'b0;
        #1;
        chk("reset_ready", lat_ready, 1'b1);
        chk("reset_tag", lat_tag, 2'd0);
        chk("reset_stall", stall, 1'b0);
        chk("reset_cnt", stall_cnt, 32'd0);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            idle();
            raddr[0] = vec[i].ra0; raddr[1] = vec[i].ra1;
            rfdata[0] = vec[i].rf0; rfdata[1] = vec[i].rf1;
            stg_we = vec[i].we; stg_ready = vec[i].rdy;
            stg_waddr[0] = vec[i].wa0; stg_waddr[1] = vec[i].wa1;
            stg_wrdata[0] = vec[i].wd0; stg_wrdata[1] = vec[i].wd1;
            #1;
            if (vec[i].dchk[0]) chk($sformatf("v%0d_rd0", i), rdata[0], vec[i].e0);
            if (vec[i].dchk[1]) chk($sformatf("v%0d_rd1", i), rdata[1], vec[i].e1);
            chk($sformatf("v%0d_stall", i), stall, vec[i].es);
            chk($sformatf("v%0d_cnt", i), stall_cnt, exp_cnt);
            if (vec[i].es) exp_cnt++;
        end

        // Scoreboard fill r1..r4
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle();
            lat_issue = 1'b1; lat_waddr = 5'(i + 1);
            #1;
            chk($sformatf("fill%0d_ready", i), lat_ready, 1'b1);
            chk($sformatf("fill%0d_tag", i), lat_tag, 32'(i));
        end
        @(negedge clk); idle();
        lat_waddr = 5'd6; raddr[0] = 5'd3;
        #1;
        chk("full_ready", lat_ready, 1'b0);
        chk("pend_stall", stall, 1'b1);
        chk("pend_cnt", stall_cnt, exp_cnt);
        exp_cnt++;

        @(negedge clk); idle();
        lat_done = 1'b1; lat_done_tag = 2'd2; lat_done_wrdata = 32'h5A;
        lat_waddr = 5'd6; raddr[0] = 5'd3; rfdata[0] = 32'h3333;
        #1;
        chk("done_fwd", rdata[0], 32'h5A);
        chk("done_stall", stall, 1'b0);
        chk("done_ready", lat_ready, 1'b0);
        chk("done_cnt", stall_cnt, exp_cnt);

        @(negedge clk); idle();
        lat_waddr = 5'd6; raddr[0] = 5'd3; rfdata[0] = 32'h3333;
        #1;
        chk("freed_ready", lat_ready, 1'b1);
        chk("freed_tag", lat_tag, 2'd2);
        chk("freed_rd", rdata[0], 32'h3333);

        @(negedge clk); idle();
        lat_waddr = 5'd6; raddr[0] = 5'd1;
        #1;
        chk("r1_stall", stall, 1'b1);
        exp_cnt++;

        // Asynchronous reset mid-cycle with three entries valid and a stall active
        @(negedge clk);
        #1;
        chk("prerst_stall", stall, 1'b1);
        chk("prerst_cnt", stall_cnt, exp_cnt);
        #2 rst = 1'b1;
        #1;
        exp_cnt = 0;
        chk("rst_cnt", stall_cnt, exp_cnt);
        chk("rst_stall", stall, 1'b0);
        chk("rst_ready", lat_ready, 1'b1);
        chk("rst_tag", lat_tag, 2'd0);

        @(negedge clk); idle();
        rst = 1'b0;
        lat_done = 1'b1; lat_done_tag = 2'd1; lat_done_wrdata = 32'h99;
        raddr[0] = 5'd2; rfdata[0] = 32'h1111;
        #1;
        chk("stale_rd", rdata[0], 32'h1111);
        chk("stale_stall", stall, 1'b0);

        @(negedge clk); idle();
        #1;
        chk("stale_tag", lat_tag, 2'd0);
        chk("stale_cnt", stall_cnt, exp_cnt);

        // Same-cycle WAW: r9 completes on tag 0 while a new r9 issues
        @(negedge clk); idle();
        lat_issue = 1'b1; lat_waddr = 5'd9;
        #1;
        chk("waw_iss0_tag", lat_tag, 2'd0);

        @(negedge clk); idle();
        lat_issue = 1'b1; lat_waddr = 5'd9;
        lat_done = 1'b1; lat_done_tag = 2'd0; lat_done_wrdata = 32'h9999;
        #1;
        chk("waw_iss1_ready", lat_ready, 1'b1);
        chk("waw_iss1_tag", lat_tag, 2'd1);

        @(negedge clk); idle();
        id_we = 1'b1; id_waddr = 5'd9; lat_waddr = 5'd9;
        #1;
        chk("waw_stall", stall, 1'b1);
        chk("waw_dup_ready", lat_ready, 1'b0);
        chk("waw_free_tag", lat_tag, 2'd0);
        exp_cnt++;

        @(negedge clk); idle();
        id_we = 1'b1; id_waddr = 5'd10;
        #1;
        chk("nowaw_stall", stall, 1'b0);
        chk("waw_cnt", stall_cnt, exp_cnt);

        // Zero register: pending r0 plus a stage writing r0
        @(negedge clk); idle();
        lat_issue = 1'b1; lat_waddr = 5'd0;
        #1;
        chk("r0_iss_tag", lat_tag, 2'd0);

        @(negedge clk); idle();
        stg_we[0] = 1'b1; stg_ready[0] = 1'b1; stg_waddr[0] = 5'd0;
        stg_wrdata[0] = 32'hFFFF_FFFF; rfdata[0] = 32'h1234;
        #1;
        chk("r0_rd", rdata[0], 32'h0);
        chk("r0_stall", stall, 1'b0);
        chk("final_cnt", stall_cnt, exp_cnt);

        @(negedge clk); idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regs_forward_sb.md
# regs_forward_sb

Parametrised successor to the single-stage register forwarder, placed in the decode stage between the register file read ports and the operand latches. It forwards from N_STAGE in-flight pipeline stages with age priority and tracks long-latency writers (divider, cache-miss loads) in a small tagged scoreboard. When an operand cannot be forwarded yet, it raises a decode stall. It also counts stall cycles for the performance counters.

## Interface
Parameters:
- READ_PORT, 2, register read ports served
- N_STAGE, 2, forwarding stages; index 0 is the youngest (EX), N_STAGE-1 the oldest
- N_PEND, 4, scoreboard entries for long-latency writers; power of two, at least 2
- TAG_W, $clog2(N_PEND), tag width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- regs_raddr_i  in  READ_PORT×5  decode read addresses
- regs_rddata_i  in  READ_PORT×32  register file data
- id_we_i, id_waddr_i  in  1, 5  decode-stage instruction writes a register
- stg_we_i  in  N_STAGE  stage holds a register write
- stg_waddr_i  in  N_STAGE×5  write address per stage
- stg_wrdata_i  in  N_STAGE×32  write data per stage
- stg_ready_i  in  N_STAGE  write data valid this cycle (low, e.g., for a load in EX)
- lat_issue_i, lat_waddr_i  in  1, 5  a long-latency op leaves decode this cycle
- lat_issue_ready_o  out  1  scoreboard can accept the issue
- lat_tag_o  out  TAG_W  tag assigned to the accepted issue
- lat_done_i, lat_done_tag_i, lat_done_wrdata_i  in  1, TAG_W, 32  long op completes
- regs_rddata_o  out  READ_PORT×32  forwarded operands
- stall_o  out  1  decode must hold
- stall_cnt_o  out  32  saturating stall-cycle count

## Operation
- Read address 0 always returns 0, never forwards and never stalls.
- Per read port, the first match wins, in this priority order: stage 0 … stage N_STAGE-1, then a completing scoreboard entry (lat_done_i with a valid tag and matching waddr, data lat_done_wrdata_i), then regs_rddata_i.
- A matching stage with stg_ready_i=0 gives no data and raises stall_o. Older sources are not consulted.
- A read address matching a valid scoreboard entry that is not completing this cycle raises stall_o.
- WAW rule: id_we_i with id_waddr_i matching such a pending entry also raises stall_o.
- Scoreboard: N_PEND entries of {valid, waddr}. The allocator picks the lowest free index.
  - lat_issue_ready_o = any free entry, and lat_waddr_i does not match a valid entry.
  - Issue with ready low is a protocol error. The block ignores it; the bench flags it.
- Completion clears the entry named by lat_done_tag_i. lat_done_i on an invalid entry is ignored.
- Issue and completion in the same cycle:
  - The completing slot is not reusable in that cycle. The allocator sees pre-update state.
  - The same waddr may issue in the cycle its old entry completes. The match check excludes completing entries.
- stall_cnt_o increments each cycle stall_o=1 and saturates at 0xFFFF_FFFF.

## Timing
- Forwarding, stall_o, lat_issue_ready_o and lat_tag_o are combinational from current inputs and registered state. Zero latency.
- Scoreboard and counter update at the rising edge of clk.
- An entry allocated at edge k is visible from cycle k+1. An entry cleared at edge k is free from cycle k+1.
- A completing entry forwards in its completion cycle. Its register file write is the writeback stage's job.
- Reset (asynchronous, mid-operation included): all entries invalid, stall_cnt_o=0.
  - Outputs immediately after reset: lat_issue_ready_o=1, lat_tag_o=0, and stall_o driven only by stage inputs.
  - In-flight completions after reset are ignored because their entries are invalid.

## Structure
- Shared package inst_decode_pkg holds pend_entry_t {valid, waddr}, the fwd_stage_t bundle {we, ready, waddr, wrdata} and the REG_ZERO constant.
- One sub-module, regs_scoreboard: owns the entries, allocator, completion, match outputs and issue_ready.
- The top level does the priority mux, stall combine and stall counter.

## Test plan
- Forward priority:
  - Stimulus: stage0 {we, ready, r5, 0x11}, stage1 {we, ready, r5, 0x22}, read r5.
  - Required: 0x11, stall_o=0.
  - Then drop stage0: 0x22.
- Load-use: stage0 {we, ready=0, r7}, stage1 ready r7 0x33, read r7.
  - Required: stall_o=1, stall_cnt_o +1 per cycle.
  - Then stage0 ready with 0xAB: output 0xAB, stall_o=0.
- Scoreboard fill:
  - Stimulus: issue r1..r4.
  - Required: tags 0,1,2,3; lat_issue_ready_o=0 after the 4th.
  - Then read r3: stall_o=1.
  - Then done tag 2 with 0x5A: read r3 returns 0x5A in the same cycle; tag 2 reallocated next cycle.
- Same-cycle WAW:
  - Stimulus: r9 pending on tag 0; done tag 0 and issue r9 in the same cycle.
  - Required: issue accepted with tag 1.
  - Then id_waddr_i=r9 with id_we_i: stall_o=1.
- Zero register: stage0 writes r0 0xFFFF_FFFF, r0 pending, read r0 -> 0, stall_o=0.
- Reset mid-operation: assert rst with 3 entries valid and a stall active.
  - Required: entries cleared asynchronously, stall_cnt_o=0.
  - A later done with stale tag 1: ignored, no forwarding.
